seq_divider_4bit: RTL and testbench

//  Iterative restoring unsigned divider: quotient = dividend / divisor, remainder = dividend % divisor.

---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 31 +++
 rtl/seq_divider_4bit.sv | 119 +++++++++++
 tb/tb_seq_divider_4bit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings
// and the default operand width with its matching step-counter width.
package div_pkg;

  localparam int DIV_WIDTH = 4;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D from R,
// keep the difference and set the new quotient bit when it does not go negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_r,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_r,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] w_r_sh;
  logic [WIDTH-1:0] w_q_sh;
  logic [WIDTH:0]   w_trial;

  assign w_r_sh  = {i_r[WIDTH-2:0], i_q[WIDTH-1]};
  assign w_q_sh  = {i_q[WIDTH-2:0], 1'b0};
  assign w_trial = {1'b0, w_r_sh} - {1'b0, i_d};

  // MSB of the widened difference is the borrow: set means R < D, so restore.
  always_comb begin
    o_r = w_r_sh;
    o_q = w_q_sh;
    if (!w_trial[WIDTH]) begin
      o_r = w_trial[WIDTH-1:0];
      o_q = {w_q_sh[WIDTH-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider_4bit.sv
// Iterative unsigned divider, one quotient bit per clock, start/done handshake.
// Optional DIV_ZERO_FAST_EN: zero divisor skips RUN and finishes the cycle after start.
module seq_divider_4bit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               L_CNT_W  = $clog2(WIDTH);
  localparam logic [L_CNT_W-1:0] CNT_LAST = L_CNT_W'(WIDTH - 1);

  state_t             r_state;
  logic [L_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_r;
  logic [WIDTH-1:0]   r_d;
  logic               r_dz_cap;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dz;

  logic [WIDTH-1:0]   w_r_nxt;
  logic [WIDTH-1:0]   w_q_nxt;

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_r (r_r),
    .i_q (r_q),
    .i_d (r_d),
    .o_r (w_r_nxt),
    .o_q (w_q_nxt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_d      <= '0;
      r_dz_cap <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_quot   <= '0;
      r_rem    <= '0;
      r_dz     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_q      <= dividend;
            r_d      <= divisor;
            r_r      <= '0;
            r_cnt    <= CNT_LAST;
            r_dz_cap <= (divisor == '0);
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              r_quot  <= '1;
              r_rem   <= dividend;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_busy  <= 1'b1;
              r_state <= S_RUN;
            end
`else
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          r_r   <= w_r_nxt;
          r_q   <= w_q_nxt;
          r_cnt <= r_cnt - 1'b1;
          // Visible results only move here, so they stay stable through the next RUN.
          if (r_cnt == '0) begin
            r_quot  <= w_q_nxt;
            r_rem   <= w_r_nxt;
            r_dz    <= r_dz_cap;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dz;

endmodule

// File: tb/tb_seq_divider_4bit.sv
// Directed plus exhaustive bench for seq_divider_4bit with a result scoreboard.
module tb_seq_divider_4bit;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int   n_checks;
  int   n_fail;
  exp_t sb[$];

  seq_divider_4bit #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [3:0] a, input logic [3:0] b);
    exp_t e;
    if (b == 4'd0) begin
      e.q  = 4'hF;
      e.r  = a;
      e.dz = 1'b1;
    end else begin
      e.q  = a / b;
      e.r  = a % b;
      e.dz = 1'b0;
    end
    return e;
  endfunction

  function automatic int exp_lat(input logic [3:0] b);
`ifdef DIV_ZERO_FAST_EN
    if (b == 4'd0) return 0;
`endif
    return 4;
  endfunction

  // Counts posedges from the current negedge until done is seen; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 64) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic compare_result(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_q"},  32'(quotient),    32'(e.q));
      check({tag, "_r"},  32'(remainder),   32'(e.r));
      check({tag, "_dz"}, 32'(div_by_zero), 32'(e.dz));
    end
  endtask

  task automatic run_op(input string tag, input logic [3:0] a, input logic [3:0] b);
    int lat;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, 32'(busy), (exp_lat(b) == 0) ? 32'd0 : 32'd1);
    wait_done(lat);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat(b)));
    compare_result(tag);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_1cyc"}, 32'(done), 32'd0);
  endtask

  initial begin
    int lat;
    logic bad;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_q",    32'(quotient), 32'd0);
    check("rst_r",    32'(remainder), 32'd0);
    check("rst_dz",   32'(div_by_zero), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("d13_3", 4'd13, 4'd3);
    run_op("d10_0", 4'd10, 4'd0);

    // Back-to-back with start held: second request is only taken once IDLE again.
    dividend = 4'd15;
    divisor  = 4'd1;
    start    = 1'b1;
    sb.push_back(model(4'd15, 4'd1));
    sb.push_back(model(4'd7, 4'd9));
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd7;
    divisor  = 4'd9;
    wait_done(lat);
    check("b2b1_lat", 32'(lat), 32'd4);
    compare_result("b2b1");
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy) start = 1'b0;
    end while (done !== 1'b1 && lat < 64);
    start = 1'b0;
    check("b2b2_gap", 32'(lat), 32'd6);
    compare_result("b2b2");
    @(posedge clk);
    @(negedge clk);

    // Reset two cycles into RUN aborts the operation.
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_q",    32'(quotient), 32'd0);
    check("abort_r",    32'(remainder), 32'd0);
    check("abort_dz",   32'(div_by_zero), 32'd0);
    reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    check("abort_no_done", 32'(bad), 32'd0);
    run_op("d12_5", 4'd12, 4'd5);

    // A start pulse while RUN must be ignored.
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    sb.push_back(model(4'd13, 4'd3));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    dividend = 4'd2;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_lat", 32'(lat), 32'd2);
    compare_result("ign");
    bad = 1'b0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) bad = 1'b1;
    end
    check("ign_no_restart", 32'(bad), 32'd0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op("exh", 4'(a), 4'(b));
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
